// File: rtl/rx_symbol_aligner.sv
// rx_symbol_aligner: comma-based 10-bit word aligner for the RX PCS path.
// Searches all ten bit offsets of a 20-bit window for K28.5 (either disparity),
// qualifies lock over LOCK_CNT consecutive same-offset commas, drops lock after
// MISALIGN_MAX consecutive off-offset commas, and emits aligned symbols.
//
// Ports:
//   Bit_Rate_Clk_10  in   symbol-rate clock
//   RST_n            in   synchronous active-low reset
//   Data_In[9:0]     in   unaligned deserializer word, bit 0 earliest
//   Data_In_Valid    in   Data_In carries a new word
//   Aligned_Data[9:0] out aligned symbol, bit 0 first bit
//   Data_Valid       out  Aligned_Data is an aligned symbol (locked)
//   Symbol_Lock      out  aligner is LOCKED
//   Comma_Det        out  Aligned_Data is K28.5 while Data_Valid
//   Align_Offset[3:0] out current bit offset (0..9)
// Optional (RX_ALIGN_STATS_EN defined):
//   Relock_Count[7:0]  out saturating count of LOCKED->UNLOCKED transitions
//   Comma_Count[15:0]  out saturating count of Comma_Det pulses

module rx_symbol_aligner #(
    parameter int unsigned LOCK_CNT     = 3,
    parameter int unsigned MISALIGN_MAX = 4,
    parameter logic [9:0]  COMMA_NEG    = 10'b0101111100
) (
    input  logic        Bit_Rate_Clk_10,
    input  logic        RST_n,
    input  logic [9:0]  Data_In,
    input  logic        Data_In_Valid,
    output logic [9:0]  Aligned_Data,
    output logic        Data_Valid,
    output logic        Symbol_Lock,
    output logic        Comma_Det,
    output logic [3:0]  Align_Offset
`ifdef RX_ALIGN_STATS_EN
    ,
    output logic [7:0]  Relock_Count,
    output logic [15:0] Comma_Count
`endif
);

    localparam int unsigned SYM_W = 10;
    localparam int unsigned WIN_W = 20;
    localparam int unsigned OFF_W = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_UNLOCKED  = 2'd0;
    localparam logic [1:0] ST_CANDIDATE = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [OFF_W-1:0] off_d;
    logic [SYM_W-1:0] prev_q, prev_d;

    logic [WIN_W-1:0] window;
    logic [SYM_W-1:0] hit_vec;
    logic             any_hit;
    logic             hit_at_off;
    logic [OFF_W-1:0] hit_off;

    logic [SYM_W-1:0] data_d;
    logic             dv_d;
    logic             cd_d;

    // Comma search over all ten candidate offsets; lowest offset wins.
    always_comb begin
        window  = {Data_In, prev_q};
        hit_vec = '0;
        hit_off = '0;
        for (int k = 0; k < int'(SYM_W); k++) begin
            hit_vec[k] = (window[k +: SYM_W] == COMMA_NEG) ||
                         (window[k +: SYM_W] == ~COMMA_NEG);
        end
        for (int k = int'(SYM_W) - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_off = OFF_W'(k);
            end
        end
        any_hit    = |hit_vec;
        hit_at_off = |(hit_vec & (SYM_W'(1) << Align_Offset));
    end

    // Next-state and registered-output values; everything holds on invalid cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        off_d   = Align_Offset;
        prev_d  = prev_q;
        if (Data_In_Valid) begin
            prev_d = Data_In;
            case (state_q)
                ST_UNLOCKED: begin
                    if (any_hit) begin
                        off_d   = hit_off;
                        cnt_d   = CNT_W'(1);
                        state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_CANDIDATE;
                    end
                end
                ST_CANDIDATE: begin
                    if (hit_at_off) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d >= CNT_W'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (any_hit) begin
                        off_d = hit_off;
                        cnt_d = CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Only a comma seen exclusively at another offset counts against lock.
                    if (any_hit && !hit_at_off) begin
                        miss_d = miss_q + CNT_W'(1);
                        if (miss_d >= CNT_W'(MISALIGN_MAX)) begin
                            state_d = ST_UNLOCKED;
                            cnt_d   = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end

        // Extract with the post-update offset so the locking comma is itself emitted.
        data_d = Data_In_Valid ? SYM_W'(window >> off_d) : Aligned_Data;
        dv_d   = Data_In_Valid && (state_d == ST_LOCKED);
        cd_d   = dv_d && ((data_d == COMMA_NEG) || (data_d == ~COMMA_NEG));
    end

    // State and output registers.
    always_ff @(posedge Bit_Rate_Clk_10) begin
        if (!RST_n) begin
            state_q      <= ST_UNLOCKED;
            cnt_q        <= '0;
            miss_q       <= '0;
            prev_q       <= '0;
            Align_Offset <= '0;
            Aligned_Data <= '0;
            Data_Valid   <= 1'b0;
            Comma_Det    <= 1'b0;
            Symbol_Lock  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_q       <= miss_d;
            prev_q       <= prev_d;
            Align_Offset <= off_d;
            Aligned_Data <= data_d;
            Data_Valid   <= dv_d;
            Comma_Det    <= cd_d;
            Symbol_Lock  <= (state_d == ST_LOCKED);
        end
    end

`ifdef RX_ALIGN_STATS_EN
    // Saturating link-health counters.
    always_ff @(posedge Bit_Rate_Clk_10) begin
        if (!RST_n) begin
            Relock_Count <= '0;
            Comma_Count  <= '0;
        end else begin
            if ((state_q == ST_LOCKED) && (state_d == ST_UNLOCKED) &&
                (Relock_Count != 8'hFF)) begin
                Relock_Count <= Relock_Count + 8'd1;
            end
            if (cd_d && (Comma_Count != 16'hFFFF)) begin
                Comma_Count <= Comma_Count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Bench for rx_symbol_aligner: builds a serial bit stream from known symbols,
// slices it into deserializer words, and predicts outputs from the known comma
// positions in that stream.

module tb_rx_symbol_aligner;

    localparam int LOCK_CNT     = 3;
    localparam int MISALIGN_MAX = 4;
    localparam logic [9:0] K_NEG = 10'h17C;
    localparam logic [9:0] K_POS = 10'h283;

    typedef struct packed {
        logic       dv;
        logic       cd;
        logic       lk;
        logic [3:0] off;
        logic [9:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST_n;
    logic [9:0] Data_In;
    logic       Data_In_Valid;
    logic [9:0] Aligned_Data;
    logic       Data_Valid;
    logic       Symbol_Lock;
    logic       Comma_Det;
    logic [3:0] Align_Offset;
`ifdef RX_ALIGN_STATS_EN
    logic [7:0]  Relock_Count;
    logic [15:0] Comma_Count;
`endif

    always #5 clk = ~clk;

    rx_symbol_aligner #(.LOCK_CNT(LOCK_CNT), .MISALIGN_MAX(MISALIGN_MAX)) dut (
        .Bit_Rate_Clk_10(clk),
        .RST_n          (RST_n),
        .Data_In        (Data_In),
        .Data_In_Valid  (Data_In_Valid),
        .Aligned_Data   (Aligned_Data),
        .Data_Valid     (Data_Valid),
        .Symbol_Lock    (Symbol_Lock),
        .Comma_Det      (Comma_Det),
        .Align_Offset   (Align_Offset)
`ifdef RX_ALIGN_STATS_EN
        ,
        .Relock_Count   (Relock_Count),
        .Comma_Count    (Comma_Count)
`endif
    );

    // Data symbols with runs of at most two equal bits, so no false commas.
    logic [9:0] dtab [5] = '{10'h155, 10'h2AA, 10'h133, 10'h0CD, 10'h266};

    bit   stream[$];
    bit   cstart[$];
    int   rd;
    int   dix;
    bit   kpol;
    exp_t exp_q[$];

    int         m_state, m_cnt, m_miss, m_off;
    logic [9:0] m_prev;
    bit         prev_real;
    int         m_commas, m_relocks;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic add_sym(input logic [9:0] v, input bit is_k);
        for (int j = 0; j < 10; j++) begin
            stream.push_back(v[j]);
            cstart.push_back(is_k && (j == 0));
        end
    endtask

    task automatic add_fill(input int n);
        for (int j = 0; j < n; j++) begin
            stream.push_back(j[0]);
            cstart.push_back(1'b0);
        end
    endtask

    task automatic add_data();
        add_sym(dtab[dix], 1'b0);
        dix = (dix + 1) % 5;
    endtask

    task automatic add_comma();
        add_sym(kpol ? K_POS : K_NEG, 1'b1);
        kpol = !kpol;
    endtask

    // n_k commas each preceded by n_d data symbols, then two trailing data symbols.
    task automatic seg(input int n_d, input int n_k);
        for (int c = 0; c < n_k; c++) begin
            for (int d = 0; d < n_d; d++) add_data();
            add_comma();
        end
        add_data();
        add_data();
    endtask

    function automatic int words_avail();
        return (stream.size() - rd) / 10;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.dv   = Data_Valid;
        o.cd   = Comma_Det;
        o.lk   = Symbol_Lock;
        o.off  = Align_Offset;
        o.data = Data_Valid ? Aligned_Data : 10'h000;
        return o;
    endfunction

    task automatic model_clear();
        m_state = 0; m_cnt = 0; m_miss = 0; m_off = 0;
        m_prev = '0; prev_real = 1'b0;
    endtask

    // Drive one word, predict from comma positions, push expectation, advance a clock.
    task automatic step(input bit valid);
        logic [9:0]  w;
        logic [19:0] win;
        int          hitk;
        exp_t        e;
        w = '0;
        if (valid) begin
            for (int j = 0; j < 10; j++) w[j] = stream[rd + j];
        end else begin
            w = 10'($urandom);
        end
        Data_In       = w;
        Data_In_Valid = valid;
        e = '0;
        if (valid) begin
            hitk = -1;
            if (prev_real) begin
                for (int k = 9; k >= 0; k--) begin
                    if (cstart[rd - 10 + k]) hitk = k;
                end
            end
            win = {w, m_prev};
            case (m_state)
                0: if (hitk >= 0) begin
                       m_off = hitk; m_cnt = 1;
                       m_state = (LOCK_CNT == 1) ? 2 : 1;
                   end
                1: if (hitk == m_off) begin
                       m_cnt++;
                       if (m_cnt == LOCK_CNT) m_state = 2;
                   end else if (hitk >= 0) begin
                       m_off = hitk; m_cnt = 1;
                   end
                default: if (hitk >= 0 && hitk != m_off) begin
                       m_miss++;
                       if (m_miss == MISALIGN_MAX) begin
                           m_state = 0; m_cnt = 0; m_miss = 0; m_relocks++;
                       end
                   end else begin
                       m_miss = 0;
                   end
            endcase
            m_prev    = w;
            prev_real = 1'b1;
            rd       += 10;
            e.lk   = (m_state == 2);
            e.dv   = e.lk;
            e.cd   = e.dv && (hitk == m_off);
            e.data = e.dv ? 10'(win >> m_off) : 10'h000;
            if (e.cd) m_commas++;
        end else begin
            e.lk = (m_state == 2);
        end
        e.off = 4'(m_off);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0; Data_In = '0; Data_In_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RST_n = 1'b1;
        model_clear();
        stream.delete(); cstart.delete(); exp_q.delete();
        rd = 0; dix = 0; kpol = 1'b0; m_commas = 0; m_relocks = 0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Data_In = 10'($urandom); Data_In_Valid = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if ({Aligned_Data, Data_Valid, Symbol_Lock, Comma_Det, Align_Offset} !== 17'h0) begin
                n_fail++;
                $display("FAIL reset_values cyc=%0d got data=%h dv=%b lk=%b cd=%b off=%0d exp all 0",
                         i, Aligned_Data, Data_Valid, Symbol_Lock, Comma_Det, Align_Offset);
            end
        end
`ifdef RX_ALIGN_STATS_EN
        n_checks++;
        if ({Relock_Count, Comma_Count} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_stats got relock=%0d comma=%0d exp 0", Relock_Count, Comma_Count);
        end
`endif
    endtask

    task automatic test_lock_shift3();
        exp_t o, e;
        int   n_cd = 0;
        do_reset();
        add_fill(3);
        seg(2, 4);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL lock3 got=%h exp=%h", o, e); end
            if (Comma_Det === 1'b1) begin
                n_cd++;
                n_checks++;
                if (Aligned_Data !== K_NEG && Aligned_Data !== K_POS) begin
                    n_fail++;
                    $display("FAIL lock3_comma_data got=%h exp 17c/283", Aligned_Data);
                end
            end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b1, 4'd3} || n_cd != 2) begin
            n_fail++;
            $display("FAIL lock3_final got lock=%b off=%0d commas=%0d exp lock=1 off=3 commas=2",
                     Symbol_Lock, Align_Offset, n_cd);
        end
    endtask

    task automatic test_no_comma();
        exp_t o, e;
        int   n_act = 0;
        do_reset();
        for (int i = 0; i < 20; i++) add_data();
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL no_comma got=%h exp=%h", o, e); end
            if (Data_Valid !== 1'b0 || Symbol_Lock !== 1'b0) n_act++;
        end
        n_checks++;
        if (n_act != 0) begin
            n_fail++;
            $display("FAIL no_comma_quiet got active_cycles=%0d exp 0", n_act);
        end
    endtask

    task automatic test_misalign();
        exp_t o, e;
        do_reset();
        add_fill(3);
        seg(2, 3);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL misalign_lock got=%h exp=%h", o, e); end
        end
        add_fill(4);
        seg(0, 4);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL misalign_drop got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL misalign_dropped got lock=%b off=%0d exp lock=0 off=3", Symbol_Lock, Align_Offset);
        end
        seg(0, 3);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL misalign_relock got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b1, 4'd7}) begin
            n_fail++;
            $display("FAIL misalign_final got lock=%b off=%0d exp lock=1 off=7", Symbol_Lock, Align_Offset);
        end
`ifdef RX_ALIGN_STATS_EN
        n_checks++;
        if (Relock_Count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_count got=%0d exp=1", Relock_Count);
        end
`endif
    endtask

    task automatic test_candidate_switch();
        exp_t o, e;
        do_reset();
        add_fill(2);
        seg(2, 2);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL cand_a got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL cand_at2 got lock=%b off=%0d exp lock=0 off=2", Symbol_Lock, Align_Offset);
        end
        add_fill(3);
        seg(2, 2);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL cand_b got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL cand_at5 got lock=%b off=%0d exp lock=0 off=5", Symbol_Lock, Align_Offset);
        end
        seg(2, 1);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL cand_c got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL cand_lock got lock=%b off=%0d exp lock=1 off=5", Symbol_Lock, Align_Offset);
        end
    endtask

    task automatic test_valid_toggle();
        exp_t o, e;
        bit   v = 1'b1;
        int   n_vw = 0, n_dv = 0;
        do_reset();
        add_fill(3);
        seg(2, 3);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL toggle_lock got=%h exp=%h", o, e); end
        end
        seg(2, 3);
        while (words_avail() > 0) begin
            step(v);
            if (v) n_vw++;
            if (Data_Valid === 1'b1) n_dv++;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL toggle got=%h exp=%h valid=%b", o, e, v); end
            if (!v) begin
                n_checks++;
                if (Data_Valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL toggle_gap got dv=%b exp 0", Data_Valid);
                end
            end
            v = !v;
        end
        n_checks++;
        if (n_dv != n_vw) begin
            n_fail++;
            $display("FAIL toggle_count got outputs=%0d exp=%0d", n_dv, n_vw);
        end
`ifdef RX_ALIGN_STATS_EN
        n_checks++;
        if (Comma_Count !== 16'(m_commas)) begin
            n_fail++;
            $display("FAIL comma_count got=%0d exp=%0d", Comma_Count, m_commas);
        end
`endif
    endtask

    task automatic test_reset_midlock();
        exp_t o, e;
        do_reset();
        add_fill(3);
        seg(2, 3);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_lock got=%h exp=%h", o, e); end
        end
        RST_n = 1'b0; Data_In = 10'($urandom); Data_In_Valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({Aligned_Data, Data_Valid, Symbol_Lock, Comma_Det, Align_Offset} !== 17'h0) begin
            n_fail++;
            $display("FAIL midrst_values got data=%h dv=%b lk=%b cd=%b off=%0d exp all 0",
                     Aligned_Data, Data_Valid, Symbol_Lock, Comma_Det, Align_Offset);
        end
        RST_n = 1'b1;
        model_clear();
        seg(2, 2);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_requal got=%h exp=%h", o, e); end
        end
        n_checks++;
        if (Symbol_Lock !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_early got lock=%b exp 0", Symbol_Lock);
        end
        seg(2, 1);
        while (words_avail() > 0) begin
            step(1'b1);
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_relock got=%h exp=%h", o, e); end
        end
        n_checks++;
        if ({Symbol_Lock, Align_Offset} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL midrst_final got lock=%b off=%0d exp lock=1 off=3", Symbol_Lock, Align_Offset);
        end
    endtask

    initial begin
        RST_n = 1'b0; Data_In = '0; Data_In_Valid = 1'b0;
        rd = 0; dix = 0; kpol = 1'b0; m_commas = 0; m_relocks = 0;
        model_clear();
        test_reset();
        test_lock_shift3();
        test_no_comma();
        test_misalign();
        test_candidate_switch();
        test_valid_toggle();
        test_reset_midlock();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
